router_input_port: RTL
======================

// Module: router_input_port
// PURPOSE
//  Receiving end of the 20-bit valid/credit link between a flit source (PE inject side or
//  neighbouring router output) and a router input. Buffers incoming flits in a FIFO,
//  returns one credit per freed slot, and presents the head flit with its XY route
//  direction to the switch allocator. One instance per router input port.
// PARAMETERS
//  DEPTH   4   FIFO slots; the transmitter resets its credit counter to DEPTH.
//  AW      2   pointer width, clog2(DEPTH); DEPTH must be a power of two, >= 2.
// PORTS
//  clk        in   1     clock, rising edge
//  RST        in   1     asynchronous, active-high reset
//  position   in   4     this router's coordinate: [1:0]=x, [3:2]=y
//  in         in   20    flit from link; [19:16] = destination {y,x}
//  vi         in   1     flit valid on 'in', one flit per cycle
//  co         out  1     credit return to transmitter, 1-cycle pulse per freed slot
//  head       out  20    flit at FIFO head
//  head_valid out  1     FIFO non-empty
//  head_dir   out  3     route for head: 1=E(x+) 2=W(x-) 3=N(y+) 4=S(y-) 5=local, 0 if empty
//  deq        in   1     switch consumes head this cycle (ignored when head_valid=0)
//  count      out  AW+1  current occupancy, 0..DEPTH
//  ovf        out  1     sticky: flit arrived with no free slot
// BEHAVIOUR
//  Reset (async, RST=1): wr/rd pointers=0, count=0, co=0, ovf=0, head_valid=0,
//   head_dir=0; head is don't-care (bench must not check). FIFO data not cleared.
//  Write: vi=1 and (count<DEPTH or effective deq) -> store 'in' at wr_ptr, wr_ptr+1 mod DEPTH.
//  Read: effective deq = deq & head_valid -> rd_ptr+1 mod DEPTH.
//  Simultaneous write+read: allowed at any occupancy including full; count unchanged.
//  Full with vi=1 and no effective deq: flit dropped, state unchanged, ovf set to 1 and
//   held until reset (protocol violation by transmitter).
//  deq while empty: no effect, no credit.
//  count: +1 on write only, -1 on read only, unchanged on both/neither.
//  Latency: flit sampled at edge N is head at N (visible after edge N) only if FIFO
//   was empty; no combinational in->head bypass. Minimum vi-to-head_valid = 1 cycle.
//  Credit: co registered; co=1 for exactly the cycle after each effective deq.
//   Back-to-back deq gives co high on consecutive cycles (one pulse per flit).
//   Credits are never issued for dropped flits.
//  head, head_valid, head_dir combinational from FIFO state and position.
//  head_dir (XY, X first), dx=dest[1:0], dy=dest[3:2], px=position[1:0], py=position[3:2]:
//   dx>px ->1; dx<px ->2; else dy>py ->3; dy<py ->4; else 5. Unsigned compare.
//  position treated as static; change mid-run only re-evaluates head_dir.
//  Reset mid-operation: all buffered flits discarded, no credits emitted for them;
//   transmitter must be reset in the same cycle.
//  Pointer wrap: DEPTH writes and reads cycle pointers back to 0 with no gap.
// TESTING
//  1 Reset: RST=1 2 cycles -> co=0, head_valid=0, count=0, ovf=0, head_dir=0.
//  2 position=4'h5, send in=20'h6_0ABC (dest y1,x2) -> next cycle head_valid=1,
//    head=20'h60ABC, head_dir=1; send 20'h5_0001 -> head_dir=5 once it reaches head.
//  3 Fill: 4 flits 20'h0_0001..20'h0_0004, deq=0 -> count=4; 5th flit 20'h0_0005
//    -> dropped, ovf=1, count=4; then 4 deq -> heads 1,2,3,4 in order, 4 co pulses.
//  4 Full + vi + deq same cycle -> write accepted, count stays 4, co=1 next cycle, ovf=0.
//  5 Stream 10 flits with deq=1 every cycle -> order preserved across wrap, exactly
//    10 co pulses, count never exceeds 1; deq on empty -> no co.
//  6 RST asserted with count=3 mid-stream -> count=0, head_valid=0 immediately, no co.

Source files
------------

// File: rtl/router_input_port_if.sv
// router_input_port_if: link-side flit/credit and switch-side head signals of a router input
interface router_input_port_if #(parameter int AW = 2);
  logic [19:0] in;
  logic        vi;
  logic        co;
  logic [19:0] head;
  logic        head_valid;
  logic [2:0]  head_dir;
  logic        deq;
  logic [AW:0] count;
  logic        ovf;
  modport master (output in, vi, deq, input co, head, head_valid, head_dir, count, ovf);
  modport slave  (input in, vi, deq, output co, head, head_valid, head_dir, count, ovf);
endinterface

// File: rtl/router_input_port.sv
// router_input_port: credit-flow input FIFO presenting the head flit with its XY route
module router_input_port #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [3:0] position,
  router_input_port_if.slave p
);
  logic [19:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic co_q, co_d, ovf_q, ovf_d;
  logic hv, full, rd_en, wr_en;
  logic [1:0] dx, dy;
  always_comb begin
    hv    = cnt_q != '0;
    full  = cnt_q == (AW+1)'(DEPTH);
    rd_en = p.deq & hv;
    wr_en = p.vi & (~full | rd_en);
    wr_d  = wr_q + AW'(wr_en);
    rd_d  = rd_q + AW'(rd_en);
    cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    co_d  = rd_en;
    // a full FIFO only drops when nothing leaves in the same cycle
    ovf_d = ovf_q | (p.vi & ~wr_en);
  end
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      co_q  <= co_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) if (wr_en) mem_q[wr_q] <= p.in;
  always_comb begin
    p.head       = mem_q[rd_q];
    p.head_valid = hv;
    p.co         = co_q;
    p.count      = cnt_q;
    p.ovf        = ovf_q;
    dx           = p.head[17:16];
    dy           = p.head[19:18];
    p.head_dir   = !hv ? 3'd0 : dx > position[1:0] ? 3'd1 : dx < position[1:0] ? 3'd2 :
                   dy > position[3:2] ? 3'd3 : dy < position[3:2] ? 3'd4 : 3'd5;
  end
endmodule
